// File: rtl/aes_pkg.sv
// Shared AES primitives for the cipher datapaths.
//  - nr_of: round count from key length
//  - GF(2^8) helpers (xtime, gf_mul, pmul_9/b/d/e, gf_inv) modulo x^8+x^4+x^3+x+1
//  - sbox / inv_sbox_f computed from the field inverse plus the affine map
//  - inv_shift_rows, inv_mix_col, inv_mix_columns on FIPS-197 byte order
//  - sub_word, rot_word, rcon_of for key expansion
//  - state_t: inverse-cipher FSM states
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] pmul_9(input logic [7:0] b); return gf_mul(b, 8'h09); endfunction
  function automatic logic [7:0] pmul_b(input logic [7:0] b); return gf_mul(b, 8'h0b); endfunction
  function automatic logic [7:0] pmul_d(input logic [7:0] b); return gf_mul(b, 8'h0d); endfunction
  function automatic logic [7:0] pmul_e(input logic [7:0] b); return gf_mul(b, 8'h0e); endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_f(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // Byte n of the state lives at [127-8n -: 8]; row r, column c is byte 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {pmul_e(a0) ^ pmul_b(a1) ^ pmul_d(a2) ^ pmul_9(a3),
            pmul_9(a0) ^ pmul_e(a1) ^ pmul_b(a2) ^ pmul_d(a3),
            pmul_d(a0) ^ pmul_9(a1) ^ pmul_e(a2) ^ pmul_b(a3),
            pmul_b(a0) ^ pmul_d(a1) ^ pmul_9(a2) ^ pmul_e(a3)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Rcon[n] = x^(n-1), n >= 1.
  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int t = 2; t <= 15; t++) if (t <= n) rc = xtime(rc);
    return rc;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_param_key_sched.sv
// Forward key expansion emitting one 128-bit round key per cycle, rk[0]..rk[NR].
//  clk, rst     clock, synchronous active-low reset
//  key_ld  in   starts (or restarts) the build from key
//  key     in   256-bit cipher key, MSB-justified
//  rk_we   out  rk is a valid round key this cycle
//  rk_idx  out  round-key index 0..NR
//  rk      out  round key
// A window of NK words starting at w[4j] is held; its first four words are
// rk[j]. Each step derives the next four words and slides the window by four.
module aes_key_sched_rk
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_ld,
  input  logic [255:0] key,
  output logic         rk_we,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam logic [3:0] NR4 = 4'(NR);

  logic [7:0][31:0] win, win_ld, win_nx;
  logic [3:0][31:0] nw;
  logic [31:0]      prev, temp;
  logic [3:0]       j;
  logic             active;
  int               wi;

  // All eight key words are loaded; words past NK are simply never consumed.
  always_comb begin
    win_ld = '0;
    for (int k = 0; k < 8; k++) win_ld[k] = key[255-32*k -: 32];
  end

  always_comb begin
    nw     = '0;
    temp   = '0;
    wi     = 0;
    prev   = win[NK-1];
    for (int k = 0; k < 4; k++) begin
      wi   = 4 * int'(j) + NK + k;
      temp = prev;
      if (wi % NK == 0)
        temp = sub_word(rot_word(prev)) ^ {rcon_of(wi / NK), 24'h0};
      else if (NK > 6 && wi % NK == 4)
        temp = sub_word(prev);
      nw[k] = win[k] ^ temp;
      prev  = nw[k];
    end
    win_nx = win;
    for (int k = 0; k < NK - 4; k++) win_nx[k] = win[k+4];
    for (int k = 0; k < 4; k++)      win_nx[NK-4+k] = nw[k];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= 1'b0;
      j      <= '0;
    end else if (key_ld) begin
      win    <= win_ld;
      j      <= '0;
      active <= 1'b1;
    end else if (active) begin
      win <= win_nx;
      j   <= j + 4'd1;
      if (j == NR4) active <= 1'b0;
    end
  end

  assign rk_we  = active;
  assign rk_idx = j;
  assign rk     = {win[0], win[1], win[2], win[3]};
endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte.
//  in_byte  in  8  substituted byte
//  out_byte out 8  InvSubBytes result
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = inv_sbox_f(in_byte);
endmodule

// File: rtl/aes_inv_cipher_param.sv
// Iterative AES inverse cipher (AES-128/192/256 by KEY_BITS), one block per NR+1 cycles.
//  clk, rst              clock, synchronous active-low reset
//  key_ld, key           load key and rebuild the round-key buffer
//  key_ready             round-key buffer complete
//  in_valid/in_ready     ciphertext handshake, text_in
//  out_valid/out_ready   plaintext handshake, text_out (registered)
//  busy                  FSM not IDLE
module aes_inv_cipher_param
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_ld,
  input  logic [255:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out,
  output logic         busy
);
  localparam int NR = nr_of(KEY_BITS);
  localparam logic [3:0] NR4 = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_inv_cipher_param: KEY_BITS must be 128, 192 or 256");
  end

  logic         rk_we;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] rk_buf [0:NR];
  logic [127:0] rk_last, rk_rd, st;
  logic [127:0] isr, isb, p, rnd;
  logic [3:0]   r;
  state_t       state, state_nx;
  logic         accept, write_out, out_free;

  aes_key_sched_rk #(.KEY_BITS(KEY_BITS)) u_ks (
    .clk    (clk),
    .rst    (rst),
    .key_ld (key_ld),
    .key    (key),
    .rk_we  (rk_we),
    .rk_idx (rk_idx),
    .rk     (rk)
  );

  always_ff @(posedge clk) begin
    if (rk_we) rk_buf[rk_idx] <= rk;
    if (rk_we && rk_idx == NR4) rk_last <= rk;
  end

  // Shared by ROUND and FINAL: InvSubBytes(InvShiftRows(st)) ^ current round key.
  assign isr = inv_shift_rows(st);
  for (genvar b = 0; b < 16; b++) begin : g_isb
    aes_inv_sbox u_sb (.in_byte(isr[8*b +: 8]), .out_byte(isb[8*b +: 8]));
  end
  assign p   = isb ^ rk_rd;
  assign rnd = inv_mix_columns(p);

  assign in_ready = key_ready & (state == IDLE) & ~key_ld;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    write_out = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = ROUND;
      ROUND: if (r == 4'd1) state_nx = FINAL;
      FINAL, HOLD: begin
        if (out_free) begin
          write_out = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx  = HOLD;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A new key invalidates whatever block is in the rounds.
    if (key_ld) begin
      state_nx  = IDLE;
      write_out = 1'b0;
    end
  end

  // rk_rd is a registered buffer read: it always holds the key the next round uses.
  always_ff @(posedge clk) begin
    if (accept) begin
      st    <= text_in ^ rk_last;
      r     <= NR4 - 4'd1;
      rk_rd <= rk_buf[NR-1];
    end else if (state == ROUND && !key_ld) begin
      st    <= rnd;
      r     <= r - 4'd1;
      rk_rd <= rk_buf[r - 4'd1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      text_out  <= '0;
    end else begin
      // Ready once the last key (rk[NR]) has landed in the buffer.
      if (key_ld)                           key_ready <= 1'b0;
      else if (rk_we && rk_idx == NR4)      key_ready <= 1'b1;
      if (write_out) begin
        text_out  <= p;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_param.sv
module tb_aes_inv_cipher_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_B2  = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic         rst;
  logic         key_ld, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
  logic [255:0] key;
  logic [127:0] text_in, text_out;
  logic         b_key_ld, b_key_ready, b_in_valid, b_in_ready, b_out_valid, b_busy;
  logic [255:0] b_key;
  logic [127:0] b_text_out;
  logic         c_key_ld, c_key_ready, c_in_valid, c_in_ready, c_out_valid, c_busy;
  logic [255:0] c_key;
  logic [127:0] c_text_out;

  int tests = 0;
  int fails = 0;

  aes_inv_cipher_param #(.KEY_BITS(128)) dut (
    .clk(clk), .rst(rst), .key_ld(key_ld), .key(key), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .text_in(text_in),
    .out_valid(out_valid), .out_ready(out_ready), .text_out(text_out), .busy(busy));

  aes_inv_cipher_param #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst(rst), .key_ld(b_key_ld), .key(b_key), .key_ready(b_key_ready),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .text_in(CT_C2),
    .out_valid(b_out_valid), .out_ready(1'b1), .text_out(b_text_out), .busy(b_busy));

  aes_inv_cipher_param #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .key_ld(c_key_ld), .key(c_key), .key_ready(c_key_ready),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .text_in(CT_C3),
    .out_valid(c_out_valid), .out_ready(1'b1), .text_out(c_text_out), .busy(c_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] k);
    int n;
    key = k; key_ld = 1'b1;
    tick;
    key_ld = 1'b0;
    n = 0;
    while (!key_ready && n < 60) begin tick; n++; end
    tests++;
    if (key_ready !== 1'b1) begin fails++; $display("FAIL key_ready_timeout: got %b want 1", key_ready); end
  endtask

  task automatic test_reset_stall;
    int n;
    logic stall_bad;
    rst = 1'b0; in_valid = 1'b1; text_in = CT_C1; key_ld = 1'b0; out_ready = 1'b1;
    tick; tick;
    tests++;
    if ({key_ready, out_valid, busy, in_ready} !== 4'b0000 || text_out !== 128'h0) begin
      fails++;
      $display("FAIL reset_state: got kr=%b ov=%b busy=%b ir=%b out=%h want all 0", key_ready, out_valid, busy, in_ready, text_out);
    end
    rst = 1'b1;
    tick; tick;
    key = KEY_C1; key_ld = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_no_key: in_ready got %b want 0", in_ready); end
    tick;
    key_ld = 1'b0;
    n = 0; stall_bad = 1'b0;
    while (!key_ready && n < 60) begin
      tick; n++;
      if (busy !== 1'b0) stall_bad = 1'b1;
    end
    tests++;
    if (stall_bad || key_ready !== 1'b1) begin
      fails++; $display("FAIL stall_until_key: busy_seen=%b key_ready=%b want 0/1", stall_bad, key_ready);
    end
    key_ld = 1'b1; #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL key_ld_wins: in_ready got %b want 0", in_ready); end
    tick;
    key_ld = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL key_ld_no_accept: busy got %b want 0", busy); end
    n = 0;
    while (!key_ready && n < 60) begin tick; n++; end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_after_key: in_ready got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    tests++;
    if (out_valid !== 1'b1 || text_out !== PT_C) begin
      fails++; $display("FAIL stall_block_pt: got ov=%b %h want 1 %h", out_valid, text_out, PT_C);
    end
    tick;
  endtask

  task automatic test_latency_128;
    int lat;
    in_valid = 1'b1; text_in = CT_C1; #1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick; lat++; end
    tests++;
    if (lat != 10) begin fails++; $display("FAIL latency_128: got %0d want 10", lat); end
    tests++;
    if (text_out !== PT_C) begin fails++; $display("FAIL pt_128: got %h want %h", text_out, PT_C); end
    tick;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL out_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_wide;
    int n, lat_b, lat_c;
    logic [127:0] pt_b, pt_c;
    b_key = KEY_C2; c_key = KEY_C3; b_key_ld = 1'b1; c_key_ld = 1'b1;
    tick;
    b_key_ld = 1'b0; c_key_ld = 1'b0;
    n = 0;
    while (!(b_key_ready && c_key_ready) && n < 80) begin tick; n++; end
    b_in_valid = 1'b1; c_in_valid = 1'b1;
    tick;
    b_in_valid = 1'b0; c_in_valid = 1'b0;
    lat_b = -1; lat_c = -1; pt_b = '0; pt_c = '0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (b_out_valid && lat_b < 0) begin lat_b = k; pt_b = b_text_out; end
      if (c_out_valid && lat_c < 0) begin lat_c = k; pt_c = c_text_out; end
    end
    tests++;
    if (lat_b != 12 || pt_b !== PT_C) begin fails++; $display("FAIL aes192: got lat=%0d %h want 12 %h", lat_b, pt_b, PT_C); end
    tests++;
    if (lat_c != 14 || pt_c !== PT_C) begin fails++; $display("FAIL aes256: got lat=%0d %h want 14 %h", lat_c, pt_c, PT_C); end
  endtask

  task automatic test_backpressure;
    int n;
    logic unstable;
    load_key(KEY_B);
    out_ready = 1'b0;
    in_valid = 1'b1; text_in = CT_B1; #1;
    tick;
    text_in = CT_B2; #1;
    n = 0;
    while (!in_ready && n < 30) begin tick; n++; end
    tick;
    in_valid = 1'b0;
    unstable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b1 || text_out !== PT_B1) unstable = 1'b1;
      tick;
    end
    tests++;
    if (unstable) begin fails++; $display("FAIL hold_first: got ov=%b %h want 1 %h", out_valid, text_out, PT_B1); end
    in_valid = 1'b1; text_in = CT_C1; #1;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL second_parked: got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1; #1;
    tick;
    tests++;
    if (out_valid !== 1'b1 || text_out !== PT_B2) begin
      fails++; $display("FAIL release_second: got ov=%b %h want 1 %h", out_valid, text_out, PT_B2);
    end
    tick;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL release_drain: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_key_abort;
    int n;
    logic leaked;
    in_valid = 1'b1; text_in = CT_B1; #1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick; tick;
    key = KEY_C1; key_ld = 1'b1;
    tick;
    key_ld = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    leaked = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    tests++;
    if (leaked) begin fails++; $display("FAIL abort_discard: out_valid seen %b want 0", leaked); end
    in_valid = 1'b1; text_in = CT_C1; #1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    tests++;
    if (out_valid !== 1'b1 || text_out !== PT_C) begin
      fails++; $display("FAIL new_key_pt: got ov=%b %h want 1 %h", out_valid, text_out, PT_C);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int n;
    in_valid = 1'b1; text_in = CT_C1; #1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tests++;
    if ({key_ready, out_valid, busy} !== 3'b000 || text_out !== 128'h0) begin
      fails++; $display("FAIL rst_round: got kr=%b ov=%b busy=%b out=%h want 0", key_ready, out_valid, busy, text_out);
    end
    load_key(KEY_C1);
    out_ready = 1'b0;
    in_valid = 1'b1; text_in = CT_C1; #1;
    tick;
    n = 0;
    while (!in_ready && n < 30) begin tick; n++; end
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 14; k++) tick;
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      fails++; $display("FAIL hold_reached: got busy=%b ov=%b want 1 1", busy, out_valid);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1; out_ready = 1'b1;
    tests++;
    if ({key_ready, out_valid, busy} !== 3'b000 || text_out !== 128'h0) begin
      fails++; $display("FAIL rst_hold: got kr=%b ov=%b busy=%b out=%h want 0", key_ready, out_valid, busy, text_out);
    end
  endtask

  initial begin
    rst = 1'b0; key_ld = 1'b0; key = '0; in_valid = 1'b0; text_in = '0; out_ready = 1'b1;
    b_key_ld = 1'b0; b_key = '0; b_in_valid = 1'b0;
    c_key_ld = 1'b0; c_key = '0; c_in_valid = 1'b0;
    test_reset_stall;
    test_latency_128;
    test_wide;
    test_backpressure;
    test_key_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
